// File: rtl/bcd5_to_bin_16.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one bit per clock.
// start/done handshake; err flags an invalid digit or a value that does not fit in B_WIDTH bits.
module bcd5_to_bin_16 #(
    parameter int unsigned N_DIGITS = 5,
    parameter int unsigned B_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  CLEARn,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [B_WIDTH-1:0]    B,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [B_WIDTH-1:0] bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [B_WIDTH-1:0] b_q, b_d;
    logic               err_q, err_d;

    logic                     digit_bad;
    logic [BCD_W+B_WIDTH-1:0] shift_w;
    logic [BCD_W-1:0]         bcd_shift;
    logic [BCD_W-1:0]         bcd_corr;
    logic [B_WIDTH-1:0]       bin_shift;

    always_comb begin
        digit_bad = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    // Each digit is corrected on its own after the shift; no borrow ripples between digits.
    always_comb begin
        shift_w   = {bcd_q, bin_q} >> 1;
        bcd_shift = shift_w[BCD_W+B_WIDTH-1:B_WIDTH];
        bin_shift = shift_w[B_WIDTH-1:0];
        bcd_corr  = bcd_shift;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8) begin
                bcd_corr[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge CLEARn) begin
        if (!CLEARn) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (digit_bad) begin
                        b_d     = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                bcd_d = bcd_corr;
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Any BCD residue left after the final iteration means the value exceeded 2^B_WIDTH-1.
                if (cnt_q == CNT_LAST) begin
                    b_d     = bin_shift;
                    err_d   = |bcd_corr;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_CONV);
        done = (state_q == S_DONE);
    end

    assign B   = b_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd5_to_bin_16.sv
// Self-checking bench for bcd5_to_bin_16: directed vector table, reset corners,
// random BCD words and binary->BCD round trips against an arithmetic reference.
module tb_bcd5_to_bin_16;

    localparam int unsigned LAT_VALID = 16;
    localparam int unsigned LAT_BAD   = 0;
    localparam int          TIMEOUT   = 40;

    logic        clk;
    logic        CLEARn;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] B;
    logic        err;

    int checks;
    int errors;

    bcd5_to_bin_16 #(.N_DIGITS(5), .B_WIDTH(16)) dut (
        .clk    (clk),
        .CLEARn (CLEARn),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .B      (B),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic [15:0] exp_b;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal value from the digits with plain arithmetic.
    function automatic void ref_conv(input logic [19:0] bcd, output logic [15:0] b, output logic e);
        int unsigned val;
        int unsigned d;
        bit bad;
        val = 0;
        bad = 0;
        for (int i = 4; i >= 0; i--) begin
            d = (bcd >> (4 * i)) & 20'hF;
            if (d > 9) bad = 1;
            val = val * 10 + d;
        end
        if (bad) begin
            b = 16'h0;
            e = 1'b1;
        end else begin
            b = val[15:0];
            e = (val > 65535);
        end
    endfunction

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    logic [15:0] hold_b;
    logic        hold_e;

    // Starts at #1 after a posedge; returns at #1 after a posedge with the DUT back in IDLE.
    task automatic run_conv(input logic [19:0] v, input bit noise,
                            output logic [15:0] gb, output logic ge,
                            output int lat, output int bcnt, output bit pulse_ok);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = noise ? 1'($urandom) : 1'b0;
        if (noise) bcd_in = 20'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) bcnt++;
            if (lat == 8 && busy) begin
                chk("B_hold_conv", {16'h0, B}, {16'h0, hold_b});
                chk("err_hold_conv", {31'h0, err}, {31'h0, hold_e});
            end
            @(posedge clk);
            #1;
            lat++;
            if (noise) begin
                start  = 1'($urandom);
                bcd_in = 20'($urandom);
            end
        end
        start = 1'b0;
        gb = B;
        ge = err;
        chk("busy_with_done", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        pulse_ok = !done;
    endtask

    task automatic conv_and_check(input string tag, input logic [19:0] v, input bit noise,
                                  input logic [15:0] eb, input logic ee, input int elat);
        logic [15:0] gb;
        logic        ge;
        int          lat;
        int          bcnt;
        bit          pok;
        run_conv(v, noise, gb, ge, lat, bcnt, pok);
        chk({tag, "_B"},    {16'h0, gb}, {16'h0, eb});
        chk({tag, "_err"},  {31'h0, ge}, {31'h0, ee});
        chk({tag, "_lat"},  32'(lat), 32'(elat));
        chk({tag, "_busy"}, 32'(bcnt), 32'(elat));
        chk({tag, "_pulse"}, {31'h0, pok}, 32'h1);
        chk({tag, "_Bkeep"}, {16'h0, B}, {16'h0, eb});
        hold_b = eb;
        hold_e = ee;
    endtask

    vec_t vecs[10];

    initial begin
        logic [15:0] eb;
        logic        ee;
        logic [19:0] v;
        bit          seen_done;

        checks = 0;
        errors = 0;
        vecs[0] = '{20'h00255, 16'h00FF, 1'b0, LAT_VALID};
        vecs[1] = '{20'h65535, 16'hFFFF, 1'b0, LAT_VALID};
        vecs[2] = '{20'h00000, 16'h0000, 1'b0, LAT_VALID};
        vecs[3] = '{20'h65536, 16'h0000, 1'b1, LAT_VALID};
        vecs[4] = '{20'h99999, 16'h869F, 1'b1, LAT_VALID};
        vecs[5] = '{20'h0A000, 16'h0000, 1'b1, LAT_BAD};
        vecs[6] = '{20'h0000F, 16'h0000, 1'b1, LAT_BAD};
        vecs[7] = '{20'h00001, 16'h0001, 1'b0, LAT_VALID};
        vecs[8] = '{20'h10000, 16'h2710, 1'b0, LAT_VALID};
        vecs[9] = '{20'h09999, 16'h270F, 1'b0, LAT_VALID};

        CLEARn = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_B",    {16'h0, B},    32'h0);
        chk("rst_err",  {31'h0, err},  32'h0);
        CLEARn = 1'b1;
        hold_b = 16'h0;
        hold_e = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            conv_and_check($sformatf("vec%0d", i), vecs[i].bcd, 1'b0,
                           vecs[i].exp_b, vecs[i].exp_e, vecs[i].exp_lat);
        end

        // Abort a conversion after 8 iterations; no done may follow.
        bcd_in = 20'h12345;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy_before", {31'h0, busy}, 32'h1);
        CLEARn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_done", {31'h0, done}, 32'h0);
        chk("mid_rst_B",    {16'h0, B},    32'h0);
        chk("mid_rst_err",  {31'h0, err},  32'h0);
        @(posedge clk);
        #1;
        CLEARn = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1;
        end
        chk("mid_rst_no_done", {31'h0, seen_done}, 32'h0);
        hold_b = 16'h0;
        hold_e = 1'b0;
        conv_and_check("after_rst", 20'h12345, 1'b0, 16'h3039, 1'b0, LAT_VALID);

        // Random words, mostly valid digits, some arbitrary nibbles.
        for (int n = 0; n < 150; n++) begin
            if (n % 4 == 0) begin
                v = 20'($urandom);
            end else begin
                for (int d = 0; d < 5; d++) v[4*d +: 4] = 4'($urandom_range(9, 0));
            end
            ref_conv(v, eb, ee);
            conv_and_check("rand", v, n[0], eb, ee,
                           (v[3:0] > 9 || v[7:4] > 9 || v[11:8] > 9 || v[15:12] > 9 || v[19:16] > 9)
                           ? LAT_BAD : LAT_VALID);
        end

        // Round trip binary -> BCD -> binary, half of them with start/bcd_in noise during CONV.
        for (int unsigned x = 0; x < 256; x++) begin
            conv_and_check("rt", to_bcd(x), x[0], 16'(x), 1'b0, LAT_VALID);
        end
        for (int n = 0; n < 40; n++) begin
            int unsigned x;
            x = $urandom_range(65535, 0);
            conv_and_check("rt_rand", to_bcd(x), n[0], 16'(x), 1'b0, LAT_VALID);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd5_to_bin_16.md
Name: bcd5_to_bin_16

Overview:
- Sequential 5-digit packed-BCD to 16-bit binary converter (reverse double-dabble). It is the decode direction of the existing binary-to-BCD display path.
- Lets switch or keypad decimal entry (e.g. SW-entered digits) be turned into binary operands for the CPU data path or test loaders.
- Uses a start/done handshake and processes one bit per clock.

Parameters:
- N_DIGITS, 5, number of BCD digits; bcd_in width is 4*N_DIGITS.
- B_WIDTH, 16, binary result width; equals the number of shift iterations.

Ports:
- clk  input  1  system clock, rising-edge.
- CLEARn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- bcd_in  input  20  packed BCD, digit 4 in [19:16] down to digit 0 in [3:0].
- busy  output  1  high while a conversion is in progress (CONV state).
- done  output  1  one-cycle pulse; result and err are valid when high.
- B  output  16  binary result; holds its value until the next done.
- err  output  1  invalid digit or overflow; valid with done, held with B.

Behaviour:
- One clock domain. Async reset: CLEARn=0 forces state IDLE and sets busy=0, done=0, B=0, err=0, counter=0, and clears the internal shift registers. Reset asserted mid-conversion aborts the conversion with no done.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at edge E0, all digits of bcd_in <=9:
  - Load bcd_reg<=bcd_in, bin_reg<=0, cnt<=0.
  - Go to CONV; busy=1.
- IDLE, start=1, any digit >9:
  - Go to DONE directly; B<=0, err<=1, done<=1.
  - Latency is 1 clock.
- CONV, each edge, one iteration:
  - Shift the concatenation {bcd_reg,bin_reg} right by 1.
  - Then, for each 4-bit digit of the shifted bcd_reg, if the digit is >=8, subtract 3. Digit corrections are independent, with no carry between digits.
  - cnt increments.
- Iteration count: at the edge where the 16th iteration (cnt==B_WIDTH-1) completes:
  - Register B<=shifted bin_reg.
  - err<=1 if the residual bcd_reg after correction is nonzero, i.e. value >65535; else err<=0.
  - done<=1, busy<=0, state<=DONE.
- Valid-input latency: start sampled at E0, iterations at E1..E16, done high for the one cycle following E16 (17 clocks).
- DONE: the next edge clears done and returns to IDLE. start is ignored in DONE, so back-to-back requests need start held or re-asserted in IDLE. Minimum spacing between accepted starts is 18 clocks.
- start in CONV or DONE is ignored; bcd_in is not re-sampled during CONV.
- Overflow: B is the value mod 2^16 and err=1, e.g. 99999 -> B=0x869F.
- B and err change only on done assertion or reset.

Test Plan:
- Reset mid-CONV (CLEARn low at iteration 8) -> busy=0, done=0, B=0, err=0 immediately. No done appears later; the next start converts normally.
- bcd_in=20'h00255, start 1 cycle -> busy high 16 cycles, done pulse exactly 17 clocks after start sample, B=16'h00FF, err=0.
- bcd_in=20'h65535 -> B=16'hFFFF, err=0. bcd_in=20'h00000 -> B=0, err=0.
- bcd_in=20'h65536 -> B=16'h0000, err=1. bcd_in=20'h99999 -> B=16'h869F, err=1.
- bcd_in=20'h0A000 -> done on the cycle after the start edge, B=0, err=1, busy never high.
- Round-trip loop: for v=0..255 and a random 16-bit set, feed the bin_16toBCD_5 output into bcd_in -> B==v, err=0. Extra start pulses during CONV are ignored, and bcd_in changes during CONV do not alter the result.
